// File: rtl/spigot_e_sequencer.sv
// rtl/spigot_e_sequencer.sv - Sale's spigot controller for e over external remainder RAM and shared divider
// Emits one BCD digit of e per out_valid/out_ready handshake, leading 2 first.
module spigot_e_sequencer #(
   parameter int unsigned N_CELLS  = 32,
   parameter int unsigned N_DIGITS = 30,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned REM_W    = 6,
   parameter int unsigned DVD_W    = 9
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              ena,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [REM_W-1:0]  ram_wdata,
   input  logic [REM_W-1:0]  ram_rdata,
   output logic              div_start,
   output logic [DVD_W-1:0]  div_dividend,
   output logic [REM_W-1:0]  div_divisor,
   input  logic              div_done,
   input  logic [3:0]        div_quot,
   input  logic [REM_W-1:0]  div_rem,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_digit,
   output logic [7:0]        out_index,
   output logic              busy,
   output logic              done
);

   typedef enum logic [3:0] {
      S_INIT, S_EMIT, S_RD, S_WAIT_RD, S_DIV, S_WAIT_DIV, S_WB, S_OUT, S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_CELLS - 1);
   localparam logic [7:0]        LAST_COUNT = 8'(N_DIGITS);

   state_t             state_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [3:0]         carry_q;
   logic [7:0]         count_q;
   logic [REM_W-1:0]   rdata_q;
   logic               we_q;
   logic [REM_W-1:0]   wdata_q;
   logic               start_q;
   logic [DVD_W-1:0]   dividend_q;
   logic [REM_W-1:0]   divisor_q;
   logic               valid_q;
   logic [3:0]         digit_q;
   logic [7:0]         index_q;
   logic               busy_q;
   logic               done_q;

   logic [DVD_W-1:0]   dividend_d;
   logic [REM_W-1:0]   divisor_d;
   logic [7:0]         count_d;

   always_comb begin
      dividend_d = DVD_W'(rdata_q) * DVD_W'(10) + DVD_W'(carry_q);
      divisor_d  = REM_W'(addr_q) + REM_W'(2);
      count_d    = count_q + 8'd1;
   end

   // The RAM address is the cell pointer itself, so a read is already presented
   // in RD and its data is on ram_rdata during WAIT_RD.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_INIT;
         addr_q     <= '0;
         carry_q    <= '0;
         count_q    <= '0;
         rdata_q    <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         start_q    <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         valid_q    <= 1'b0;
         digit_q    <= '0;
         index_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            S_INIT: begin
               busy_q  <= 1'b1;
               wdata_q <= REM_W'(1);
               // we_q high means the write to addr_q lands in this cycle.
               if (we_q) begin
                  if (addr_q == LAST_ADDR) begin
                     we_q      <= 1'b0;
                     valid_q   <= 1'b1;
                     digit_q   <= 4'd2;
                     index_q   <= 8'd0;
                     state_q   <= S_EMIT;
                  end else begin
                     addr_q <= addr_q + ADDR_W'(1);
                     we_q   <= ena;
                  end
               end else begin
                  we_q <= ena;
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  count_q <= 8'd1;
                  addr_q  <= LAST_ADDR;
                  carry_q <= '0;
                  state_q <= S_RD;
               end
            end
            S_RD: begin
               if (ena) state_q <= S_WAIT_RD;
            end
            S_WAIT_RD: begin
               rdata_q <= ram_rdata;
               state_q <= S_DIV;
            end
            S_DIV: begin
               if (ena) begin
                  start_q    <= 1'b1;
                  dividend_q <= dividend_d;
                  divisor_q  <= divisor_d;
                  state_q    <= S_WAIT_DIV;
               end
            end
            S_WAIT_DIV: begin
               if (div_done) begin
                  carry_q <= div_quot;
                  we_q    <= 1'b1;
                  wdata_q <= div_rem;
                  state_q <= S_WB;
               end
            end
            S_WB: begin
               we_q <= 1'b0;
               if (addr_q == '0) begin
                  valid_q <= 1'b1;
                  digit_q <= carry_q;
                  index_q <= count_q;
                  state_q <= S_OUT;
               end else begin
                  addr_q  <= addr_q - ADDR_W'(1);
                  state_q <= S_RD;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  count_q <= count_d;
                  if (count_d == LAST_COUNT) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     addr_q  <= LAST_ADDR;
                     carry_q <= '0;
                     state_q <= S_RD;
                  end
               end
            end
            S_DONE: begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
            default: state_q <= S_INIT;
         endcase
      end
   end

   assign ram_addr     = addr_q;
   assign ram_we       = we_q;
   assign ram_wdata    = wdata_q;
   assign div_start    = start_q;
   assign div_dividend = dividend_q;
   assign div_divisor  = divisor_q;
   assign out_valid    = valid_q;
   assign out_digit    = digit_q;
   assign out_index    = index_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_spigot_e_sequencer.sv
// tb/tb_spigot_e_sequencer.sv - scoreboard bench for spigot_e_sequencer with RAM and divider models
module tb_spigot_e_sequencer;
   localparam int NC = 32;
   localparam int ND = 30;
   localparam int AW = 5;
   localparam int RW = 6;
   localparam int DW = 9;

   localparam logic [3:0] E_DIG [0:ND-1] = '{
      4'd2, 4'd7, 4'd1, 4'd8, 4'd2, 4'd8, 4'd1, 4'd8, 4'd2, 4'd8,
      4'd4, 4'd5, 4'd9, 4'd0, 4'd4, 4'd5, 4'd2, 4'd3, 4'd5, 4'd3,
      4'd6, 4'd0, 4'd2, 4'd8, 4'd7, 4'd4, 4'd7, 4'd1, 4'd3, 4'd5};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetn = 1'b0;
   logic          ena = 1'b0;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [RW-1:0] ram_wdata;
   logic [RW-1:0] ram_rdata = '0;
   logic          div_start;
   logic [DW-1:0] div_dividend;
   logic [RW-1:0] div_divisor;
   logic          div_done = 1'b0;
   logic [3:0]    div_quot = '0;
   logic [RW-1:0] div_rem = '0;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    out_digit;
   logic [7:0]    out_index;
   logic          busy;
   logic          done;

   logic rdy_man = 1'b0;
   logic rdy_rand = 1'b0;
   logic rand_bit = 1'b0;
   assign out_ready = rdy_rand ? rand_bit : rdy_man;

   logic [42:0] all_out;
   assign all_out = {ram_addr, ram_we, ram_wdata, div_start, div_dividend, div_divisor,
                     out_valid, out_digit, out_index, busy, done};

   spigot_e_sequencer #(.N_CELLS(NC), .N_DIGITS(ND), .ADDR_W(AW), .REM_W(RW), .DVD_W(DW)) dut (
      .clk(clk), .resetn(resetn), .ena(ena),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem),
      .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit), .out_index(out_index),
      .busy(busy), .done(done));

   int pass_cnt = 0;
   int total_cnt = 0;

   // Remainder RAM: registered read, one cycle after the address.
   logic [RW-1:0] mem [0:NC-1];
   int n_we = 0;
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
         n_we <= n_we + 1;
      end
      ram_rdata <= mem[ram_addr];
   end

   // Divider: latency lat_fix or random 1..12 cycles after the start cycle.
   int lat_fix = 1;
   bit lat_rand = 1'b0;
   int div_cnt = 0;
   int n_start = 0;
   int n_done = 0;
   int overlap = 0;
   int unstable = 0;
   logic [DW-1:0] cap_dvd = '0;
   logic [RW-1:0] cap_dvs = '0;
   always @(posedge clk) begin
      int l;
      div_done <= 1'b0;
      if (div_start) begin
         n_start <= n_start + 1;
         if (div_cnt != 0) overlap <= overlap + 1;
         cap_dvd <= div_dividend;
         cap_dvs <= div_divisor;
         l = lat_rand ? int'($urandom_range(1, 12)) : lat_fix;
         if (l == 1) begin
            div_done <= 1'b1;
            div_quot <= 4'(div_dividend / DW'(div_divisor));
            div_rem  <= RW'(div_dividend % DW'(div_divisor));
            n_done   <= n_done + 1;
         end else begin
            div_cnt <= l - 1;
         end
      end else if (div_cnt != 0) begin
         if (div_cnt == 1) begin
            div_done <= 1'b1;
            div_quot <= 4'(cap_dvd / DW'(cap_dvs));
            div_rem  <= RW'(cap_dvd % DW'(cap_dvs));
            n_done   <= n_done + 1;
            if (div_dividend !== cap_dvd || div_divisor !== cap_dvs) unstable <= unstable + 1;
         end
         div_cnt <= div_cnt - 1;
      end
   end

   always @(posedge clk) begin
      #1 rand_bit = 1'($urandom_range(0, 1));
   end

   logic [11:0] got_q [$];
   logic [11:0] exp_q [$];
   always @(negedge clk) begin
      if (resetn && out_valid && out_ready) got_q.push_back({out_index, out_digit});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      ena = 1'b0;
      rdy_man = 1'b0;
      rdy_rand = 1'b0;
      lat_rand = 1'b0;
      repeat (3) step();
      resetn = 1'b1;
   endtask

   task automatic wait_done(input int max, output bit ok);
      int c = 0;
      while (!done && c < max) begin
         step();
         c++;
      end
      ok = done;
   endtask

   task automatic wait_valid(input int max, output bit ok);
      int c = 0;
      while (!out_valid && c < max) begin
         step();
         c++;
      end
      ok = out_valid;
   endtask

   task automatic fill_expected(input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back({8'(i), E_DIG[i]});
   endtask

   task automatic test_reset();
      int w0;
      resetn = 1'b0;
      ena = 1'b0;
      repeat (2) step();
      total_cnt++;
      if (all_out !== 43'd0) $display("FAIL reset_outputs got %0h want 0", all_out);
      else pass_cnt++;
      resetn = 1'b1;
      w0 = n_we;
      repeat (5) step();
      total_cnt++;
      if (n_we - w0 !== 0) $display("FAIL init_blocked_by_ena got %0d writes want 0", n_we - w0);
      else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL busy_after_reset got %0b want 1", busy);
      else pass_cnt++;
   endtask

   task automatic test_init();
      int nw = 0, bad = 0, first_c = -1, last_c = -1, c = 0;
      ena = 1'b1;
      while (!out_valid && c < 100) begin
         step();
         c++;
         if (ram_we) begin
            if (first_c < 0) first_c = c;
            if (ram_addr !== AW'(nw) || ram_wdata !== RW'(1)) bad++;
            nw++;
            last_c = c;
         end
      end
      total_cnt++;
      if (nw !== NC) $display("FAIL init_write_count got %0d want %0d", nw, NC);
      else pass_cnt++;
      total_cnt++;
      if (bad !== 0) $display("FAIL init_write_addr_data got %0d bad want 0", bad);
      else pass_cnt++;
      total_cnt++;
      if (last_c - first_c !== NC - 1) $display("FAIL init_consecutive got %0d want %0d", last_c - first_c, NC - 1);
      else pass_cnt++;
      total_cnt++;
      if (c !== last_c + 1) $display("FAIL emit_after_init got cycle %0d want %0d", c, last_c + 1);
      else pass_cnt++;
      total_cnt++;
      if ({out_valid, out_digit, out_index} !== {1'b1, 4'd2, 8'd0})
         $display("FAIL first_digit got v=%0b d=%0d i=%0d want v=1 d=2 i=0", out_valid, out_digit, out_index);
      else pass_cnt++;
   endtask

   task automatic test_full_run();
      bit ok;
      int base, s0, w0;
      logic [11:0] e;
      do_reset();
      lat_fix = 5;
      fill_expected(ND);
      base = got_q.size();
      ena = 1'b1;
      rdy_man = 1'b1;
      wait_done(20000, ok);
      total_cnt++;
      if (!ok) $display("FAIL full_run_timeout got done=%0b want 1", done);
      else pass_cnt++;
      total_cnt++;
      if (got_q.size() - base !== ND) $display("FAIL full_run_count got %0d want %0d", got_q.size() - base, ND);
      else pass_cnt++;
      for (int i = 0; i < ND && base + i < got_q.size(); i++) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (got_q[base + i] !== e) $display("FAIL full_run_digit%0d got %0h want %0h", i, got_q[base + i], e);
         else pass_cnt++;
      end
      total_cnt++;
      if ({done, busy, out_valid} !== 3'b100)
         $display("FAIL done_flags got done=%0b busy=%0b valid=%0b want 1 0 0", done, busy, out_valid);
      else pass_cnt++;
      s0 = n_start;
      w0 = n_we;
      repeat (50) step();
      total_cnt++;
      if ((n_start - s0) + (n_we - w0) !== 0) $display("FAIL quiet_after_done got %0d events want 0", (n_start - s0) + (n_we - w0));
      else pass_cnt++;
      total_cnt++;
      if (overlap !== 0 || unstable !== 0) $display("FAIL full_run_divider got overlap=%0d unstable=%0d want 0 0", overlap, unstable);
      else pass_cnt++;
   endtask

   task automatic test_ready_hold();
      bit ok;
      int s0, w0, bad = 0;
      do_reset();
      lat_fix = 3;
      ena = 1'b1;
      wait_valid(200, ok);
      rdy_man = 1'b1;
      step();
      rdy_man = 1'b0;
      wait_valid(3000, ok);
      total_cnt++;
      if (!ok || out_index !== 8'd1) $display("FAIL hold_reach_index1 got valid=%0b index=%0d want 1 1", out_valid, out_index);
      else pass_cnt++;
      s0 = n_start;
      w0 = n_we;
      repeat (20) begin
         step();
         if (out_valid !== 1'b1 || out_digit !== 4'd7 || out_index !== 8'd1) bad++;
      end
      total_cnt++;
      if (bad !== 0) $display("FAIL hold_stable got %0d bad cycles want 0", bad);
      else pass_cnt++;
      total_cnt++;
      if ((n_start - s0) + (n_we - w0) !== 0) $display("FAIL hold_no_activity got %0d events want 0", (n_start - s0) + (n_we - w0));
      else pass_cnt++;
      rdy_man = 1'b1;
      step();
      rdy_man = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL hold_valid_drop got %0b want 0", out_valid);
      else pass_cnt++;
      wait_valid(3000, ok);
      total_cnt++;
      if ({ok, out_digit, out_index} !== {1'b1, 4'd1, 8'd2})
         $display("FAIL hold_next_digit got ok=%0b d=%0d i=%0d want 1 1 2", ok, out_digit, out_index);
      else pass_cnt++;
   endtask

   task automatic test_ena_pause();
      bit ok;
      int base, c, s0, w0, d0;
      logic [11:0] e;
      do_reset();
      lat_fix = 5;
      fill_expected(ND);
      base = got_q.size();
      ena = 1'b1;
      rdy_man = 1'b1;
      c = 0;
      while (got_q.size() - base < 3 && c < 5000) begin step(); c++; end
      c = 0;
      while (!div_start && c < 500) begin step(); c++; end
      total_cnt++;
      if (div_start !== 1'b1) $display("FAIL pause_find_start got %0b want 1", div_start);
      else pass_cnt++;
      ena = 1'b0;
      step();
      s0 = n_start;
      w0 = n_we;
      d0 = n_done;
      repeat (30) step();
      total_cnt++;
      if (n_start - s0 !== 0) $display("FAIL pause_no_start got %0d want 0", n_start - s0);
      else pass_cnt++;
      total_cnt++;
      if ({n_done - d0, n_we - w0} !== {32'd1, 32'd1})
         $display("FAIL pause_done_consumed got done=%0d we=%0d want 1 1", n_done - d0, n_we - w0);
      else pass_cnt++;
      ena = 1'b1;
      wait_done(20000, ok);
      total_cnt++;
      if (got_q.size() - base !== ND) $display("FAIL pause_count got %0d want %0d", got_q.size() - base, ND);
      else pass_cnt++;
      for (int i = 0; i < ND && base + i < got_q.size(); i++) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (got_q[base + i] !== e) $display("FAIL pause_digit%0d got %0h want %0h", i, got_q[base + i], e);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      bit ok;
      int base, o0, u0;
      logic [11:0] e;
      do_reset();
      lat_rand = 1'b1;
      rdy_rand = 1'b1;
      o0 = overlap;
      u0 = unstable;
      fill_expected(ND);
      base = got_q.size();
      ena = 1'b1;
      wait_done(40000, ok);
      total_cnt++;
      if (!ok || got_q.size() - base !== ND) $display("FAIL random_count got ok=%0b n=%0d want 1 %0d", ok, got_q.size() - base, ND);
      else pass_cnt++;
      for (int i = 0; i < ND && base + i < got_q.size(); i++) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (got_q[base + i] !== e) $display("FAIL random_digit%0d got %0h want %0h", i, got_q[base + i], e);
         else pass_cnt++;
      end
      total_cnt++;
      if ((overlap - o0) + (unstable - u0) !== 0) $display("FAIL random_divider got overlap=%0d unstable=%0d want 0 0", overlap - o0, unstable - u0);
      else pass_cnt++;
      rdy_rand = 1'b0;
      lat_rand = 1'b0;
   endtask

   task automatic test_reset_mid_div();
      bit ok;
      int base, c, d0, nw;
      logic [11:0] e;
      do_reset();
      lat_fix = 10;
      base = got_q.size();
      ena = 1'b1;
      rdy_man = 1'b1;
      c = 0;
      while (got_q.size() - base < 5 && c < 5000) begin step(); c++; end
      c = 0;
      while (!div_start && c < 500) begin step(); c++; end
      step();
      step();
      d0 = n_done;
      rdy_man = 1'b0;
      resetn = 1'b0;
      #1;
      total_cnt++;
      if (all_out !== 43'd0) $display("FAIL midreset_outputs got %0h want 0", all_out);
      else pass_cnt++;
      step();
      step();
      resetn = 1'b1;
      fill_expected(3);
      base = got_q.size();
      nw = 0;
      c = 0;
      while (!out_valid && c < 200) begin
         step();
         c++;
         if (ram_we) nw++;
      end
      total_cnt++;
      if (n_done - d0 !== 1) $display("FAIL midreset_late_done got %0d pulses want 1", n_done - d0);
      else pass_cnt++;
      total_cnt++;
      if (nw !== NC) $display("FAIL midreset_reinit got %0d writes want %0d", nw, NC);
      else pass_cnt++;
      total_cnt++;
      if ({out_valid, out_digit, out_index} !== {1'b1, 4'd2, 8'd0})
         $display("FAIL midreset_first got v=%0b d=%0d i=%0d want 1 2 0", out_valid, out_digit, out_index);
      else pass_cnt++;
      rdy_man = 1'b1;
      c = 0;
      while (got_q.size() - base < 3 && c < 3000) begin step(); c++; end
      for (int i = 0; i < 3; i++) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (base + i >= got_q.size()) $display("FAIL midreset_digit%0d got none want %0h", i, e);
         else if (got_q[base + i] !== e) $display("FAIL midreset_digit%0d got %0h want %0h", i, got_q[base + i], e);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_full_run();
      test_ready_hold();
      test_ena_pause();
      test_random();
      test_reset_mid_div();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
